// File: rtl/ntt_fsm.sv
// Forward-NTT controller: loads N coefficients, sequences DEPTH-1 Cooley-Tukey layers across
// two ping-pong RAM banks, then streams the result. Produces addresses and strobes only.
module ntt_fsm #(
  parameter int DEPTH  = 8,
  parameter int BF_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DEPTH-1:0] ld_addr,
  output logic             ld_we,
  output logic             bf_valid,
  output logic [DEPTH-1:0] rd_addr_a,
  output logic [DEPTH-1:0] rd_addr_b,
  output logic [DEPTH-2:0] zeta_idx,
  output logic             rd_bank,
  output logic             wr_en,
  output logic [DEPTH-1:0] wr_addr_a,
  output logic [DEPTH-1:0] wr_addr_b,
  output logic             wr_bank,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] out_addr,
  output logic             busy,
  output logic             done
);

  localparam int N      = 1 << DEPTH;
  localparam int LAYERS = DEPTH - 1;
  localparam int LW     = $clog2(DEPTH);
  localparam logic UNLOAD_BANK = 1'(LAYERS % 2);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOAD   = 5'b00010,
    CALC   = 5'b00100,
    DRAIN  = 5'b01000,
    UNLOAD = 5'b10000
  } state_t;

  state_t          state, state_n;
  logic [DEPTH-1:0] cnt, cnt_n;
  logic [LW-1:0]    layer, layer_n;
  logic             done_q, done_n;

  logic [BF_LAT-1:0]            dly_v;
  logic [BF_LAT-1:0]            dly_k;
  logic [BF_LAT-1:0][DEPTH-1:0] dly_a;
  logic [BF_LAT-1:0][DEPTH-1:0] dly_b;

  // Butterfly span halves each layer, from N/2 in layer 0 down to 2 in the last layer.
  logic [LW-1:0]    s;
  logic [LW:0]      s1;
  logic [DEPTH-1:0] c_ext, len, blk, addr_a;

  always_comb begin
    s      = LW'(DEPTH - 1) - layer;
    s1     = {1'b0, s} + (LW+1)'(1);
    c_ext  = {1'b0, cnt[DEPTH-2:0]};
    len    = DEPTH'(1) << s;
    blk    = c_ext >> s;
    addr_a = (blk << s1) | (c_ext & (len - DEPTH'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      layer  <= '0;
      done_q <= 1'b0;
    end else if (set) begin
      state  <= state_n;
      cnt    <= cnt_n;
      layer  <= layer_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    layer_n = layer;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        cnt_n   = '0;
      end
      LOAD: if (in_valid) begin
        cnt_n = cnt + DEPTH'(1);
        if (cnt == DEPTH'(N - 1)) begin
          state_n = CALC;
          cnt_n   = '0;
          layer_n = '0;
        end
      end
      CALC: begin
        cnt_n = cnt + DEPTH'(1);
        if (cnt == DEPTH'(N/2 - 1)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      // DRAIN reuses cnt to wait out the butterfly latency before the next layer reads.
      DRAIN: begin
        cnt_n = cnt + DEPTH'(1);
        if (cnt == DEPTH'(BF_LAT - 1)) begin
          cnt_n = '0;
          if (layer == LW'(LAYERS - 1)) begin
            state_n = UNLOAD;
          end else begin
            layer_n = layer + LW'(1);
            state_n = CALC;
          end
        end
      end
      UNLOAD: if (out_ready) begin
        cnt_n = cnt + DEPTH'(1);
        if (cnt == DEPTH'(N - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == LOAD);
  assign ld_addr   = in_ready ? cnt : '0;
  assign ld_we     = in_valid & in_ready & set;
  assign bf_valid  = (state == CALC);
  assign rd_addr_a = bf_valid ? addr_a : '0;
  assign rd_addr_b = bf_valid ? addr_a + len : '0;
  assign zeta_idx  = bf_valid ? ((DEPTH-1)'(1) << layer) + blk[DEPTH-2:0] : '0;
  assign rd_bank   = (state == CALC || state == DRAIN) ? layer[0] :
                     (state == UNLOAD) ? UNLOAD_BANK : 1'b0;
  assign out_valid = (state == UNLOAD);
  assign out_addr  = out_valid ? cnt : '0;
  assign busy      = (state != IDLE);
  assign done      = done_q;

  // Write-back strobe is gated by set so a frozen pipeline never repeats a write.
  assign wr_en     = dly_v[BF_LAT-1] & set;
  assign wr_addr_a = dly_a[BF_LAT-1];
  assign wr_addr_b = dly_b[BF_LAT-1];
  assign wr_bank   = dly_k[BF_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_v <= '0;
      dly_k <= '0;
      dly_a <= '0;
      dly_b <= '0;
    end else if (set) begin
      dly_v[0] <= bf_valid;
      dly_k[0] <= bf_valid & ~rd_bank;
      dly_a[0] <= rd_addr_a;
      dly_b[0] <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        dly_v[i] <= dly_v[i-1];
        dly_k[i] <= dly_k[i-1];
        dly_a[i] <= dly_a[i-1];
        dly_b[i] <= dly_b[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ntt_fsm.sv
// Self-checking bench for ntt_fsm: reference issue trace built from the textbook NTT loop nest,
// write-back checked through a scoreboard of expected writes with due cycles.
module tb_ntt_fsm;

  localparam int DEPTH  = 8;
  localparam int BF_LAT = 4;
  localparam int N      = 256;
  localparam int HALF   = 128;
  localparam int LAYERS = 7;
  localparam int PER    = HALF + BF_LAT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic             in_ready, ld_we, bf_valid, rd_bank, wr_en, wr_bank, out_valid, busy, done;
  logic [DEPTH-1:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
  logic [DEPTH-2:0] zeta_idx;
  logic [63:0]      all_out;

  typedef struct { int a; int b; int z; } iss_t;
  typedef struct { int a; int b; int bank; int due; } wr_t;

  iss_t trace[$];
  wr_t  wq[$];
  int   total = 0;
  int   bad = 0;

  ntt_fsm #(.DEPTH(DEPTH), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .reset(reset), .set(set), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ld_addr(ld_addr), .ld_we(ld_we), .bf_valid(bf_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .zeta_idx(zeta_idx), .rd_bank(rd_bank),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .wr_bank(wr_bank),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign all_out = {in_ready, ld_addr, ld_we, bf_valid, rd_addr_a, rd_addr_b, zeta_idx, rd_bank,
                    wr_en, wr_addr_a, wr_addr_b, wr_bank, out_valid, out_addr, busy, done};

  // Reference order of butterflies: outer span loop, block loop, then pairs inside a block.
  task automatic build_trace;
    iss_t e;
    int kz = 1;
    for (int len = HALF; len >= 2; len = len / 2) begin
      for (int st = 0; st < N; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          e.a = j;
          e.b = j + len;
          e.z = kz;
          trace.push_back(e);
        end
        kz++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (all_out !== 64'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", all_out, 64'd0);
    end
    set = 1'b1;
    #1;
    total++;
    if (all_out !== 64'd0) begin
      bad++;
      $display("[TB] FAIL reset_with_set got=%h exp=%h", all_out, 64'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_without_start busy=%b exp=0", busy);
    end
  endtask

  task automatic test_load(input string name);
    logic [31:0] got, exp;
    logic hold, gap;
    int i = 0, holds = 0, gaps = 0, cyc = 0;
    set = 1'b1;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({busy, in_ready, bf_valid} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL %s load_entry got=%b exp=110", name, {busy, in_ready, bf_valid});
    end
    while (i < N && cyc < 400) begin
      hold = (i == 50 && holds < 2);
      gap  = (i == 100 && gaps < 3);
      set = !hold;
      in_valid = !gap;
      #1;
      got = 32'({in_ready, ld_addr, ld_we});
      exp = 32'({1'b1, 8'(i), !hold && !gap});
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL %s load_beat i=%0d got=%h exp=%h", name, i, got, exp);
      end
      @(posedge clk);
      #1;
      if (hold) holds++;
      else if (gap) gaps++;
      else i++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    set = 1'b1;
    total++;
    if (i != N) begin
      bad++;
      $display("[TB] FAIL %s load_timeout beats=%0d exp=%0d", name, i, N);
    end
    #1;
    got = 32'({in_ready, bf_valid, rd_addr_a, rd_addr_b, zeta_idx, rd_bank});
    exp = 32'({1'b0, 1'b1, 8'd0, 8'd128, 7'd1, 1'b0});
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s first_calc got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_calc(input int stall_at, input int abort_at, input string name);
    logic [31:0] got, exp;
    iss_t e;
    wr_t  w;
    int   l, p, reps, wr_layer;
    wr_layer = 0;
    wq.delete();
    for (int k = 0; k < LAYERS * PER; k++) begin
      l = k / PER;
      p = k % PER;
      reps = (k == stall_at) ? 11 : 1;
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        total++;
        if (all_out !== 64'd0) begin
          bad++;
          $display("[TB] FAIL %s abort_now got=%h exp=%h", name, all_out, 64'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (all_out !== 64'd0) begin
          bad++;
          $display("[TB] FAIL %s abort_edge got=%h exp=%h", name, all_out, 64'd0);
        end
        reset = 1'b0;
        wq.delete();
        return;
      end
      for (int r = 0; r < reps; r++) begin
        set = (r == reps - 1);
        #1;
        if (p < HALF) begin
          e = trace[l * HALF + p];
          got = 32'({bf_valid, rd_addr_a, rd_addr_b, zeta_idx, rd_bank, out_valid});
          exp = 32'({1'b1, 8'(e.a), 8'(e.b), 7'(e.z), 1'(l % 2), 1'b0});
        end else begin
          got = 32'({bf_valid, rd_bank, out_valid});
          exp = 32'({1'b0, 1'(l % 2), 1'b0});
        end
        total++;
        if (got !== exp) begin
          bad++;
          $display("[TB] FAIL %s issue k=%0d r=%0d got=%h exp=%h", name, k, r, got, exp);
        end
        if (set && wq.size() > 0 && wq[0].due == k) begin
          w = wq.pop_front();
          got = 32'({wr_en, wr_addr_a, wr_addr_b, wr_bank});
          exp = 32'({1'b1, 8'(w.a), 8'(w.b), 1'(w.bank)});
        end else begin
          got = 32'(wr_en);
          exp = 32'd0;
        end
        if (wr_en === 1'b1) wr_layer++;
        total++;
        if (got !== exp) begin
          bad++;
          $display("[TB] FAIL %s writeback k=%0d set=%b got=%h exp=%h", name, k, set, got, exp);
        end
        if (set && p < HALF) begin
          w.a = e.a;
          w.b = e.b;
          w.bank = (l % 2 == 0) ? 1 : 0;
          w.due = k + BF_LAT;
          wq.push_back(w);
        end
        if (set && p == PER - 1) begin
          total++;
          if (wr_layer != HALF) begin
            bad++;
            $display("[TB] FAIL %s layer_writes layer=%0d got=%0d exp=%0d", name, l, wr_layer, HALF);
          end
          wr_layer = 0;
        end
        @(posedge clk);
        #1;
      end
    end
    set = 1'b1;
    #1;
    total++;
    if ({bf_valid, out_valid, rd_bank, busy, out_addr} !== {4'b0111, 8'd0}) begin
      bad++;
      $display("[TB] FAIL %s unload_entry got=%h exp=%h", name,
               {bf_valid, out_valid, rd_bank, busy, out_addr}, {4'b0111, 8'd0});
    end
  endtask

  task automatic test_unload(input string name);
    logic [31:0] got, exp;
    logic acc;
    int beats = 0, cyc = 0;
    while (beats < N && cyc < 1000) begin
      out_ready = (cyc % 2 == 0);
      #1;
      got = 32'({out_valid, out_addr, rd_bank, done, busy});
      exp = 32'({1'b1, 8'(beats), 1'b1, 1'b0, 1'b1});
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL %s unload_beat n=%0d got=%h exp=%h", name, beats, got, exp);
      end
      acc = out_ready;
      @(posedge clk);
      #1;
      if (acc) beats++;
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (beats != N) begin
      bad++;
      $display("[TB] FAIL %s unload_timeout beats=%0d exp=%0d", name, beats, N);
    end
    #1;
    total++;
    if ({done, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL %s done_pulse got=%b exp=100", name, {done, busy, out_valid});
    end
    @(posedge clk);
    #1;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL %s done_clear got=%b exp=00", name, {done, busy});
    end
  endtask

  initial begin
    build_trace;
    test_reset;
    test_load("run1");
    test_calc(-1, -1, "run1");
    test_unload("run1");
    test_load("stall");
    test_calc(2 * PER + 60, -1, "stall");
    test_unload("stall");
    test_load("abort");
    test_calc(-1, 3 * PER + 40, "abort");
    test_load("rerun");
    test_calc(-1, -1, "rerun");
    test_unload("rerun");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
